// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// fc_pkg : shared FSM state encoding and word saturation helper
// Rev 1.0
// ============================================================================
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fc_state_e;

    // Clamp v to the signed range of a width-bit word; caller truncates the result.
    function automatic logic signed [63:0] sat_word(input logic signed [63:0] v,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac.sv
`default_nettype none
// ============================================================================
// fc_mac : bias-preloaded signed accumulator with floor shift and saturation
// Rev 1.0
// ============================================================================
module fc_mac
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 35
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_bias_i,
    input  logic                 acc_en_i,
    input  logic [WORD_SIZE-1:0] x_data_i,
    input  logic [WORD_SIZE-1:0] w_data_i,
    output logic [WORD_SIZE-1:0] z_o
);

    localparam int PW = 2 * WORD_SIZE;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [PW-1:0]    w_x_ext;
    logic signed [PW-1:0]    w_w_ext;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [63:0]      w_wide;

    assign w_x_ext    = {{WORD_SIZE{x_data_i[WORD_SIZE-1]}}, x_data_i};
    assign w_w_ext    = {{WORD_SIZE{w_data_i[WORD_SIZE-1]}}, w_data_i};
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-WORD_SIZE){w_data_i[WORD_SIZE-1]}}, w_data_i} <<< FRAC_BITS;
    assign w_sum      = acc_q + w_prod_ext;

    // The output includes the product still in flight, so the final term needs no extra cycle.
    assign w_shift = w_sum >>> FRAC_BITS;
    assign w_wide  = {{(64-ACC_W){w_shift[ACC_W-1]}}, w_shift};
    assign z_o     = WORD_SIZE'(sat_word(w_wide, WORD_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load_bias_i) begin
            acc_q <= w_bias_ext;
        end else if (acc_en_i) begin
            acc_q <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_output_layer.sv
`default_nettype none
// ============================================================================
// fc_output_layer : sequential fully-connected layer, one MAC per cycle
// Rev 1.0
// ============================================================================
module fc_output_layer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IN_SIZE    = 84,
    parameter int LAYER_SIZE = 10
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        rd_en,
    output logic [$clog2(IN_SIZE)-1:0]                  x_addr,
    input  logic [WORD_SIZE-1:0]                        x_data,
    output logic [$clog2(LAYER_SIZE*(IN_SIZE+1))-1:0]   w_addr,
    input  logic [WORD_SIZE-1:0]                        w_data,
    output logic [WORD_SIZE-1:0]                        Z [LAYER_SIZE],
    output logic                                        out_valid,
    input  logic                                        out_ready
);

    localparam int XA_W      = $clog2(IN_SIZE);
    localparam int WA_W      = $clog2(LAYER_SIZE * (IN_SIZE + 1));
    localparam int JW        = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;
    localparam int ACC_W     = 2 * WORD_SIZE + $clog2(IN_SIZE + 1);
    localparam int BIAS_BASE = LAYER_SIZE * IN_SIZE;

    fc_state_e              state_q;
    fc_state_e              state_d;
    logic [XA_W-1:0]        i_q;
    logic [XA_W-1:0]        i_d;
    logic [JW-1:0]          j_q;
    logic [JW-1:0]          j_d;
    logic                   w_load_bias;
    logic                   w_acc_en;
    logic                   w_z_we;
    logic [WORD_SIZE-1:0]   w_z;
    logic [WORD_SIZE-1:0]   z_q [LAYER_SIZE];

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        rd_en       = 1'b0;
        x_addr      = '0;
        w_addr      = '0;
        w_load_bias = 1'b0;
        w_acc_en    = 1'b0;
        w_z_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    j_d     = '0;
                    state_d = BIAS;
                end
            end
            BIAS: begin
                rd_en   = 1'b1;
                w_addr  = WA_W'(BIAS_BASE + int'(j_q));
                i_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                rd_en  = 1'b1;
                x_addr = i_q;
                w_addr = WA_W'(int'(j_q) * IN_SIZE + int'(i_q));
                // Data returning in the first MAC cycle is the bias read issued in BIAS.
                if (i_q == '0) begin
                    w_load_bias = 1'b1;
                end else begin
                    w_acc_en = 1'b1;
                end
                if (i_q == XA_W'(IN_SIZE - 1)) begin
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                w_z_we = 1'b1;
                if (j_q == JW'(LAYER_SIZE - 1)) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = BIAS;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAYER_SIZE; k++) begin
                z_q[k] <= '0;
            end
        end else if (w_z_we) begin
            z_q[j_q] <= w_z;
        end
    end

    fc_mac #(
        .WORD_SIZE (WORD_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bias_i (w_load_bias),
        .acc_en_i    (w_acc_en),
        .x_data_i    (x_data),
        .w_data_i    (w_data),
        .z_o         (w_z)
    );

    for (genvar g = 0; g < LAYER_SIZE; g++) begin : g_z_out
        assign Z[g] = z_q[g];
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fc_output_layer.sv
`default_nettype none
// ============================================================================
// tb_fc_output_layer : directed vectors for a 4-input, 3-neuron layer
// Rev 1.0
// ============================================================================
module tb_fc_output_layer;

    localparam int W  = 16;
    localparam int F  = 8;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int NW = L * (N + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_ready;
    logic        busy;
    logic        rd_en;
    logic [1:0]  x_addr;
    logic [3:0]  w_addr;
    logic [15:0] x_data;
    logic [15:0] w_data;
    logic [15:0] Z [L];
    logic        out_valid;

    logic [15:0] xmem [N];
    logic [15:0] wmem [NW];

    int n_checks = 0;
    int n_pass   = 0;

    fc_output_layer #(
        .WORD_SIZE  (W),
        .FRAC_BITS  (F),
        .IN_SIZE    (N),
        .LAYER_SIZE (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xmem[x_addr];
            w_data <= wmem[w_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv,
                        input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        for (int k = 0; k < N; k++) xmem[k] = xv;
        for (int k = 0; k < L * N; k++) wmem[k] = wv;
        wmem[L*N+0] = b0;
        wmem[L*N+1] = b1;
        wmem[L*N+2] = b2;
    endtask

    task automatic run_eval(input string tag);
        int lat;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val({tag, "_bias_rd"}, {busy, rd_en, w_addr}, {1'b1, 1'b1, 4'd12});
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check_val({tag, "_latency"}, lat, 18);
    endtask

    task automatic check_z(input string tag, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2);
        check_val({tag, "_z0"}, Z[0], e0);
        check_val({tag, "_z1"}, Z[1], e1);
        check_val({tag, "_z2"}, Z[2], e2);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_val({tag, "_release"}, {out_valid, busy}, 2'b00);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        x_data    = '0;
        w_data    = '0;
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
        check_val("reset_ctl", {busy, rd_en, out_valid, x_addr, w_addr}, '0);
        check_z("reset", 16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_val("idle_no_start", busy, 1'b0);

        // 1.0 * 0.5 summed over four inputs
        fill(16'h0100, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
        run_eval("basic");
        check_z("basic", 16'h0200, 16'h0200, 16'h0200);
        handshake("basic");

        fill(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0200);
        run_eval("bias");
        check_z("bias", 16'h0000, 16'h0100, 16'h0200);
        handshake("bias");

        fill(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0180);
        for (int k = 0; k < N; k++) begin
            wmem[k]     = 16'h7FFF;
            wmem[N + k] = 16'h8000;
        end
        run_eval("sat");
        check_z("sat", 16'h7FFF, 16'h8000, 16'h0180);
        handshake("sat");

        // Neuron 2 sees a single -0.5 LSB-scale product: floor gives -1, truncation would give 0
        fill(16'h0001, 16'hFF80, 16'h0000, 16'h0000, 16'h0000);
        wmem[2*N+1] = 16'h0000;
        wmem[2*N+2] = 16'h0000;
        wmem[2*N+3] = 16'h0000;
        run_eval("floor");
        check_z("floor", 16'hFFFE, 16'hFFFE, 16'hFFFF);
        handshake("floor");

        // Distinct weights per position catch address ordering errors
        xmem[0] = 16'h0100; xmem[1] = 16'h0200; xmem[2] = 16'hFF00; xmem[3] = 16'h0080;
        wmem[0] = 16'h0100; wmem[1] = 16'h0100; wmem[2]  = 16'h0100; wmem[3]  = 16'h0100;
        wmem[4] = 16'h0080; wmem[5] = 16'hFF00; wmem[6]  = 16'h0000; wmem[7]  = 16'h0200;
        wmem[8] = 16'h0000; wmem[9] = 16'h0000; wmem[10] = 16'h0200; wmem[11] = 16'h0000;
        wmem[12] = 16'h0040; wmem[13] = 16'h0000; wmem[14] = 16'h0100;
        run_eval("mixed");
        check_z("mixed", 16'h02C0, 16'hFF80, 16'hFF00);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk) start = (k == 1);
            @(posedge clk);
            #1;
            check_val("hold_ctl", {out_valid, busy}, 2'b11);
            check_val("hold_z", {Z[0], Z[1]}, {16'h02C0, 16'hFF80});
        end
        @(negedge clk) begin
            start     = 1'b1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1 check_val("hs_release", {out_valid, busy}, 2'b00);
        @(negedge clk) begin
            start     = 1'b0;
            out_ready = 1'b0;
        end
        @(posedge clk);
        #1 check_val("hs_start_ignored", busy, 1'b0);
        check_val("z_kept_idle", Z[2], 16'hFF00);

        // Mid-evaluation reset
        fill(16'h0100, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_val("pre_rst_busy", {busy, rd_en}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_ctl", {busy, rd_en, out_valid, x_addr, w_addr}, '0);
        check_z("midrst", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_val("no_resume", busy, 1'b0);
        run_eval("fresh");
        check_z("fresh", 16'h0200, 16'h0200, 16'h0200);
        handshake("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_output_layer.md
FC_OUTPUT_LAYER -- requirements
Module: fc_output_layer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of every word.
REQ-003 SHALL have parameter IN_SIZE, default 84, input vector length.
REQ-004 SHALL have parameter LAYER_SIZE, default 10, neuron count.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  request one layer evaluation.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port rd_en  output  1  read enable for both memories.
REQ-010 SHALL have port x_addr  output  $clog2(IN_SIZE)  input-vector memory address.
REQ-011 SHALL have port x_data  input  WORD_SIZE  input word, valid one cycle after rd_en.
REQ-012 SHALL have port w_addr  output  $clog2(LAYER_SIZE*(IN_SIZE+1))  weight/bias memory address.
REQ-013 SHALL have port w_data  input  WORD_SIZE  weight or bias word, valid one cycle after rd_en.
REQ-014 SHALL have port Z  output  LAYER_SIZE x WORD_SIZE unpacked array  neuron outputs, Z[j] = neuron j.
REQ-015 SHALL have port out_valid  output  1  Z is complete and stable.
REQ-016 SHALL have port out_ready  input  1  downstream argmax stage accepts Z.

Function
REQ-017 SHALL use FSM states IDLE, BIAS, MAC, DRAIN, DONE.
REQ-018 SHALL leave IDLE for BIAS only when start=1 in IDLE; start is ignored in all other states.
REQ-019 SHALL, in BIAS, drive rd_en=1 and w_addr=LAYER_SIZE*IN_SIZE+j for current neuron j; one cycle.
REQ-020 SHALL, in MAC, spend exactly IN_SIZE cycles with rd_en=1, x_addr=i, w_addr=j*IN_SIZE+i, i=0..IN_SIZE-1.
REQ-021 SHALL load accumulator with bias sign-extended and shifted left by FRAC_BITS when bias data returns, then add each returning x_data*w_data signed product.
REQ-022 SHALL, in DRAIN (one cycle, rd_en=0), add the last product and write Z[j]; then go to BIAS for j+1, or DONE after j=LAYER_SIZE-1.
REQ-023 SHALL use accumulator width 2*WORD_SIZE+$clog2(IN_SIZE+1); no intermediate overflow.
REQ-024 SHALL form Z[j] as accumulator arithmetic-shifted right FRAC_BITS (truncation toward minus infinity), saturated to signed WORD_SIZE range.
REQ-025 SHALL assert out_valid exactly LAYER_SIZE*(IN_SIZE+2) cycles after the edge that samples start.
REQ-026 SHALL hold out_valid and Z stable in DONE until out_ready=1; on that edge go to IDLE, out_valid=0 next cycle.
REQ-027 SHALL NOT accept start on the DONE-to-IDLE handshake edge, even if start=1.
REQ-028 SHALL keep Z unchanged from DONE until DRAIN of neuron 0 of the next evaluation.
REQ-029 SHALL drive rd_en=0 in IDLE, DRAIN, DONE.

Reset
REQ-030 SHALL, on rst_n=0 at any time incl. mid-evaluation, asynchronously force state IDLE, busy=0, rd_en=0, out_valid=0, x_addr=0, w_addr=0, accumulator=0, all Z[j]=0.
REQ-031 SHALL, after rst_n deassertion, need a new start; no partial result is resumed.

Structure
REQ-032 SHALL place FSM state enum and a saturate-to-word function in shared package fc_pkg.
REQ-033 SHALL implement accumulate, shift, saturate in sub-module fc_mac; fc_output_layer holds FSM, counters, Z registers.

Verification (WORD_SIZE=16, FRAC_BITS=8, IN_SIZE=4, LAYER_SIZE=3; latency 18)
REQ-034 SHALL cover: all x=0x0100, all w=0x0080, biases 0, start -> out_valid after 18 cycles, Z={0x0200,0x0200,0x0200}.
REQ-035 SHALL cover: all w=0, biases {0x0000,0x0100,0x0200} -> Z={0x0000,0x0100,0x0200}.
REQ-036 SHALL cover: x=0x7FFF, w=0x7FFF for neuron 0 and 0x8000 for neuron 1 -> Z[0]=0x7FFF, Z[1]=0x8000.
REQ-037 SHALL cover: x=0x0001, w=0xFF80, bias 0 -> Z[j]=0xFFFE (floor truncation).
REQ-038 SHALL cover: out_ready low 5 cycles in DONE with start pulsed -> Z, out_valid stable, no new evaluation; out_ready=1 -> out_valid=0, busy=0 next cycle.
REQ-039 SHALL cover: rst_n low at cycle 7 of an evaluation -> all outputs 0 immediately; fresh start then yields REQ-034 result in 18 cycles.
